// File: rtl/ifetch_queue_pkg.sv
// Shared types and default parameter values for the instruction-fetch queue.
package ifetch_queue_pkg;

    localparam int unsigned DEF_PC_W     = 10;
    localparam int unsigned DEF_INSTR_W  = 32;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Registered FIFO holding fetched {pc, instruction} entries; flush empties it in one cycle.
module ifetch_queue_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_PC_W + DEF_INSTR_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Flush wins over both ports; guards make over/underflow impossible.
    assign do_pop  = pop & (count_q != '0) & ~flush;
    assign do_push = push & ((count_q != FULL_CNT) | do_pop) & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch: one outstanding memory request at a time feeding a small queue,
// with redirect flush and discard of stale responses.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned PC_W     = DEF_PC_W,
    parameter int unsigned INSTR_W  = DEF_INSTR_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned RESET_PC = DEF_RESET_PC
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         IM_enable,
    output logic                         IM_read,
    output logic [PC_W-1:0]              IM_address,
    input  logic                         IM_ready,
    input  logic [INSTR_W-1:0]           instruction,
    input  logic                         redirect,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic                         inst_valid,
    output logic [INSTR_W-1:0]           inst_data,
    output logic [PC_W-1:0]              inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = PC_W + INSTR_W;
    localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W + 1)'(DEPTH);
    localparam logic [PC_W-1:0]  RESET_PC_C = PC_W'(RESET_PC);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;
    logic            push, pop, room;
    logic [CNT_W:0]  occ_after;
    logic [ENT_W-1:0] head_entry;

    assign pop  = inst_valid & inst_ready;
    assign push = (state_q == REQ) & IM_ready & ~redirect;

    // Occupancy once this cycle's push/pop settle; a new request needs a free slot beyond it.
    assign occ_after = {1'b0, queue_count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
    assign room      = (occ_after < DEPTH_C);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // An unanswered request must still complete on the bus; its data is dropped.
            if ((state_q != IDLE) && !IM_ready) state_d = DRAIN;
            else                               state_d = REQ;
        end else begin
            unique case (state_q)
                IDLE:  state_d = room ? REQ : IDLE;
                REQ: begin
                    if (IM_ready) begin
                        fetch_pc_d = fetch_pc_q + PC_W'(1);
                        state_d    = room ? REQ : IDLE;
                    end
                end
                DRAIN: if (IM_ready) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
        // Latch a fresh address only when a new request starts; hold it while pending.
        if ((state_d == REQ) && ((state_q != REQ) || IM_ready || redirect)) begin
            req_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC_C;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign IM_enable  = (state_q != IDLE);
    assign IM_read    = IM_enable;
    assign IM_address = IM_enable ? req_addr_q : '0;

    ifetch_queue_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) inst_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data  ({fetch_pc_q, instruction}),
        .pop        (pop),
        .head_valid (inst_valid),
        .head_data  (head_entry),
        .count      (queue_count)
    );

    assign inst_pc   = head_entry[ENT_W-1:INSTR_W];
    assign inst_data = head_entry[INSTR_W-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: memory model with wait states, consumer checks pc/data.
module tb_ifetch_queue;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               IM_enable, IM_read;
    logic [PC_W-1:0]    IM_address;
    logic               IM_ready = 1'b0;
    logic [INSTR_W-1:0] instruction = '0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               inst_valid;
    logic [INSTR_W-1:0] inst_data;
    logic [PC_W-1:0]    inst_pc;
    logic               inst_ready = 1'b0;
    logic [CNT_W-1:0]   queue_count;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;
    int   epoch   = 0;
    int   waits   = 0;
    int   wait_cnt = 0;
    bit   mem_force = 1'b0;
    bit   cons_en   = 1'b0;

    ifetch_queue #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IM_enable   (IM_enable),
        .IM_read     (IM_read),
        .IM_address  (IM_address),
        .IM_ready    (IM_ready),
        .instruction (instruction),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    // Data carries the reset epoch so entries fetched before a reset are distinguishable.
    function automatic logic [INSTR_W-1:0] mk_instr(input int ep, input logic [PC_W-1:0] a);
        logic [7:0] tag;
        tag = ep[7:0];
        return {tag, 14'h1234, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_run(input logic [PC_W-1:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + PC_W'(i);
            e.data = mk_instr(epoch, e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_dut();
        rst     = 1'b0;
        cons_en = 1'b0;
        exp_q.delete();
        epoch++;
        repeat (2) tick();
        check_eq("rst_en",    32'(IM_enable),   32'd0);
        check_eq("rst_addr",  32'(IM_address),  32'd0);
        check_eq("rst_valid", 32'(inst_valid),  32'd0);
        check_eq("rst_count", 32'(queue_count), 32'd0);
        rst = 1'b1;
    endtask

    task automatic redirect_to(input logic [PC_W-1:0] pc, input int n);
        redirect    = 1'b1;
        redirect_pc = pc;
        exp_q.delete();
        expect_run(pc, n);
        tick();
        redirect = 1'b0;
    endtask

    // Memory: answers after `waits` idle cycles of a held request.
    always @(negedge clk) begin
        if (mem_force) begin
            IM_ready    = 1'b1;
            instruction = mk_instr(epoch, '0);
            wait_cnt    = 0;
        end else if (!rst || !IM_enable) begin
            IM_ready = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= waits) begin
            IM_ready    = 1'b1;
            instruction = mk_instr(epoch, IM_address);
            wait_cnt    = 0;
        end else begin
            IM_ready = 1'b0;
            wait_cnt++;
        end
    end

    // Consumer: the head seen here is what the next rising edge pops.
    always @(negedge clk) begin
        inst_ready = rst && cons_en && (exp_q.size() != 0);
        if (inst_ready && inst_valid && !redirect) begin
            mon_e = exp_q.pop_front();
            check_eq("head_pc",   32'(inst_pc), 32'(mon_e.pc));
            check_eq("head_data", inst_data,    mon_e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        // Zero-wait memory, consumer always ready: back-to-back delivery.
        waits = 0;
        reset_dut();
        expect_run(10'h000, 4);
        cons_en = 1'b1;
        tick();
        check_eq("first_en",    32'(IM_enable),  32'd1);
        check_eq("first_rd",    32'(IM_read),    32'd1);
        check_eq("first_addr",  32'(IM_address), 32'd0);
        check_eq("first_noval", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("seq_valid", 32'(inst_valid),  32'd1);
            check_eq("seq_pc",    32'(inst_pc),     32'(i));
            check_eq("seq_count", 32'(queue_count), 32'd1);
        end
        wait_drain(50);

        // Consumer stalled: exactly DEPTH fetches, then resume at address 4.
        reset_dut();
        repeat (12) tick();
        check_eq("full_count", 32'(queue_count), 32'(DEPTH));
        check_eq("full_en",    32'(IM_enable),   32'd0);
        check_eq("full_head",  32'(inst_pc),     32'd0);
        expect_run(10'h000, 6);
        cons_en = 1'b1;
        tick();
        check_eq("resume_en",   32'(IM_enable),  32'd1);
        check_eq("resume_addr", 32'(IM_address), 32'd4);
        wait_drain(100);

        // Two wait states, redirect while request to 0x005 is pending.
        waits = 2;
        reset_dut();
        expect_run(10'h000, 5);
        cons_en = 1'b1;
        k = 0;
        tick();
        while (!(IM_enable && IM_address == 10'h005) && k < 200) begin
            tick();
            k++;
        end
        check_eq("pend_addr", 32'(IM_address), 32'h005);
        redirect_to(10'h1F0, 4);
        check_eq("drain_count", 32'(queue_count), 32'd0);
        check_eq("drain_valid", 32'(inst_valid),  32'd0);
        check_eq("drain_en",    32'(IM_enable),   32'd1);
        check_eq("drain_addr",  32'(IM_address),  32'h005);
        wait_drain(200);

        // Let the queue fill and go idle, then redirect across the PC wrap.
        repeat (20) tick();
        check_eq("idle_en", 32'(IM_enable), 32'd0);
        waits = 0;
        redirect_to(10'h3FE, 4);
        check_eq("wrap_addr",  32'(IM_address),  32'h3FE);
        check_eq("wrap_count", 32'(queue_count), 32'd0);
        wait_drain(100);

        // Asynchronous reset mid-request with three entries held.
        waits = 3;
        reset_dut();
        k = 0;
        tick();
        while (!(queue_count == CNT_W'(3) && IM_enable) && k < 200) begin
            tick();
            k++;
        end
        check_eq("pre_count", 32'(queue_count), 32'd3);
        rst = 1'b0;
        #1;
        check_eq("arst_en",    32'(IM_enable),   32'd0);
        check_eq("arst_rd",    32'(IM_read),     32'd0);
        check_eq("arst_addr",  32'(IM_address),  32'd0);
        check_eq("arst_valid", 32'(inst_valid),  32'd0);
        check_eq("arst_count", 32'(queue_count), 32'd0);
        cons_en   = 1'b0;
        mem_force = 1'b1;
        exp_q.delete();
        epoch++;
        tick();
        rst = 1'b1;
        tick();
        check_eq("late_ready_count", 32'(queue_count), 32'd0);
        check_eq("post_en",          32'(IM_enable),   32'd1);
        check_eq("post_addr",        32'(IM_address),  32'd0);
        mem_force = 1'b0;
        expect_run(10'h000, 2);
        cons_en = 1'b1;
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
